// File: rtl/fp16_dot_accum_ctrl.sv
// FP16 dot-product controller: streams (a,b) pairs into four interleaved partial-sum lanes on an
// external pipelined FMA, then reduces the four lanes with two more FMA rounds into one result.
module fp16_dot_accum_ctrl #(
   parameter int FMA_LAT = 4,
   parameter int LEN_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic             fma_in_valid,
   output logic [15:0]      fma_a,
   output logic [15:0]      fma_b,
   output logic [15:0]      fma_c,
   input  logic             fma_out_valid,
   input  logic [15:0]      fma_out,
   output logic             done,
   output logic [15:0]      result
);

   localparam logic [15:0] FP16_ONE = 16'h3C00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_RED1,
      S_RED2,
      S_FIN
   } state_t;

   state_t                      state_q, state_d;
   logic [3:0][15:0]            part_q, part_d;
   logic [3:0]                  pend_q, pend_d;
   logic [1:0]                  slot_q, slot_d;
   logic [LEN_W-1:0]            len_q, len_d;
   logic [LEN_W-1:0]            issued_q, issued_d;
   logic [1:0]                  red_q, red_d;
   logic [15:0]                 result_q, result_d;
   logic [FMA_LAT-1:0]          tv_q;
   logic [FMA_LAT-1:0][1:0]     tt_q;

   logic       iss;
   logic [1:0] iss_tag;
   logic       ret;
   logic [1:0] ret_tag;
   logic       ret_hit_slot;

   // A return only counts if its tag slot is still live; reset empties the pipe so late results die.
   assign ret          = fma_out_valid && tv_q[FMA_LAT-1] && (state_q != S_IDLE);
   assign ret_tag      = tt_q[FMA_LAT-1];
   assign ret_hit_slot = ret && (ret_tag == slot_q);
   assign busy         = (state_q != S_IDLE);
   assign fma_in_valid = iss;
   assign result       = result_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         part_q   <= '0;
         pend_q   <= '0;
         slot_q   <= '0;
         len_q    <= '0;
         issued_q <= '0;
         red_q    <= '0;
         result_q <= '0;
         tv_q     <= '0;
         tt_q     <= '0;
      end else begin
         state_q  <= state_d;
         part_q   <= part_d;
         pend_q   <= pend_d;
         slot_q   <= slot_d;
         len_q    <= len_d;
         issued_q <= issued_d;
         red_q    <= red_d;
         result_q <= result_d;
         tv_q     <= {tv_q[FMA_LAT-2:0], iss};
         tt_q     <= {tt_q[FMA_LAT-2:0], iss_tag};
      end
   end

   always_comb begin
      state_d  = state_q;
      part_d   = part_q;
      pend_d   = pend_q;
      slot_d   = slot_q;
      len_d    = len_q;
      issued_d = issued_q;
      red_d    = red_q;
      result_d = result_q;
      iss      = 1'b0;
      iss_tag  = 2'd0;
      fma_a    = 16'h0000;
      fma_b    = 16'h0000;
      fma_c    = 16'h0000;
      in_ready = 1'b0;
      done     = 1'b0;

      // Retire first so a same-cycle re-issue on that lane can set pending again below.
      if (ret) begin
         part_d[ret_tag] = fma_out;
         pend_d[ret_tag] = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d    = len;
               issued_d = '0;
               slot_d   = 2'd0;
               red_d    = 2'd0;
               part_d   = '0;
               pend_d   = '0;
               if (len != '0) begin
                  state_d = S_ACCUM;
               end else begin
                  result_d = 16'h0000;
                  state_d  = S_FIN;
               end
            end
         end

         S_ACCUM: begin
            slot_d = slot_q + 2'd1;
            if (issued_q == len_q) begin
               state_d = S_DRAIN;
            end else begin
               in_ready = !pend_q[slot_q] || ret_hit_slot;
               if (in_valid && in_ready) begin
                  iss           = 1'b1;
                  iss_tag       = slot_q;
                  fma_a         = in_a;
                  fma_b         = in_b;
                  // Bypass the lane value arriving this cycle, since part_q is not yet updated.
                  fma_c         = ret_hit_slot ? fma_out : part_q[slot_q];
                  pend_d[slot_q] = 1'b1;
                  issued_d      = issued_q + 1'b1;
               end
            end
         end

         S_DRAIN: begin
            if (pend_q == 4'b0000) begin
               state_d = S_RED1;
            end
         end

         S_RED1: begin
            if (red_q == 2'd0) begin
               iss       = 1'b1;
               iss_tag   = 2'd0;
               fma_a     = part_q[0];
               fma_b     = FP16_ONE;
               fma_c     = part_q[1];
               pend_d[0] = 1'b1;
               red_d     = 2'd1;
            end else if (red_q == 2'd1) begin
               iss       = 1'b1;
               iss_tag   = 2'd2;
               fma_a     = part_q[2];
               fma_b     = FP16_ONE;
               fma_c     = part_q[3];
               pend_d[2] = 1'b1;
               red_d     = 2'd2;
            end else if (pend_q == 4'b0000) begin
               red_d   = 2'd0;
               state_d = S_RED2;
            end
         end

         S_RED2: begin
            if (red_q == 2'd0) begin
               iss       = 1'b1;
               iss_tag   = 2'd0;
               fma_a     = part_q[0];
               fma_b     = FP16_ONE;
               fma_c     = part_q[2];
               pend_d[0] = 1'b1;
               red_d     = 2'd1;
            end else if (ret) begin
               result_d = fma_out;
               state_d  = S_FIN;
            end
         end

         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fp16_dot_accum_ctrl.sv
// Bench for fp16_dot_accum_ctrl: two DUTs (FMA latency 4 and 6) driven by an FP16 FMA model;
// expected dot products come from exact real arithmetic over small integer operands.
module tb_fp16_dot_accum_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_s[2];
   logic [7:0]  len_s[2];
   logic        busy_s[2];
   logic        in_valid_s[2];
   logic        in_ready_s[2];
   logic [15:0] in_a_s[2];
   logic [15:0] in_b_s[2];
   logic        fiv_s[2];
   logic [15:0] fa_s[2];
   logic [15:0] fb_s[2];
   logic [15:0] fc_s[2];
   logic        fov_s[2];
   logic [15:0] fo_s[2];
   logic        done_s[2];
   logic [15:0] res_s[2];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         fp16_dot_accum_ctrl #(.FMA_LAT(gi == 0 ? 4 : 6), .LEN_W(8)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_s[gi]), .len(len_s[gi]), .busy(busy_s[gi]),
            .in_valid(in_valid_s[gi]), .in_ready(in_ready_s[gi]), .in_a(in_a_s[gi]), .in_b(in_b_s[gi]),
            .fma_in_valid(fiv_s[gi]), .fma_a(fa_s[gi]), .fma_b(fb_s[gi]), .fma_c(fc_s[gi]),
            .fma_out_valid(fov_s[gi]), .fma_out(fo_s[gi]), .done(done_s[gi]), .result(res_s[gi])
         );
      end
   endgenerate

   int          checks = 0;
   int          fails = 0;
   int          cyc = 0;
   logic        line_v[2][16];
   logic [15:0] line_d[2][16];
   logic [15:0] ea[64];
   logic [15:0] eb[64];
   int          n_el = 0;
   int          idx = 0;
   bit          tog = 0;
   int          issues = 0;
   int          dones = 0;
   int          stalls = 0;
   int          done_cyc = 0;
   int          exp_res = 0;

   function automatic int lat_of(input int u);
      return (u == 0) ? 4 : 6;
   endfunction

   function automatic real fp2r(input logic [15:0] h);
      int  e;
      real v;
      e = int'(h[14:10]);
      if (e == 0) begin
         v = real'(h[9:0]) / 16777216.0;
      end else if (e == 31) begin
         v = 1.0e9;
      end else begin
         v = 1.0 + real'(h[9:0]) / 1024.0;
         if (e > 15) repeat (e - 15) v = v * 2.0;
         else        repeat (15 - e) v = v / 2.0;
      end
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2fp(input real v);
      logic s;
      real  m;
      int   e;
      int   mt;
      s = (v < 0.0);
      m = s ? -v : v;
      if (m == 0.0) return 16'h0000;
      e = 15;
      while (m >= 2.0 && e < 60) begin m = m / 2.0; e++; end
      while (m < 1.0 && e > -40) begin m = m * 2.0; e--; end
      mt = int'((m - 1.0) * 1024.0);
      if (mt >= 1024) begin mt = 0; e++; end
      if (e >= 31) return {s, 5'h1f, 10'h000};
      if (e <= 0)  return {s, 15'h0000};
      return {s, e[4:0], mt[9:0]};
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // One clock: drive FMA returns and stream inputs at negedge, then observe once settled.
   task automatic step(input int u, input bit st, input logic [7:0] ln);
      int s;
      int w;
      @(negedge clk);
      cyc++;
      s = cyc % 16;
      for (int v = 0; v < 2; v++) begin
         fov_s[v]      = line_v[v][s];
         fo_s[v]       = line_d[v][s];
         line_v[v][s]  = 1'b0;
         in_valid_s[v] = 1'b0;
         start_s[v]    = 1'b0;
      end
      start_s[u] = st;
      len_s[u]   = ln;
      if (idx < n_el && (!tog || (cyc % 2) == 0)) begin
         in_valid_s[u] = 1'b1;
         in_a_s[u]     = ea[idx];
         in_b_s[u]     = eb[idx];
      end
      #1;
      for (int v = 0; v < 2; v++) begin
         if (fiv_s[v]) begin
            w = (cyc + lat_of(v)) % 16;
            line_v[v][w] = 1'b1;
            line_d[v][w] = r2fp(fp2r(fa_s[v]) * fp2r(fb_s[v]) + fp2r(fc_s[v]));
            if (v == u) issues++;
         end
         if (!busy_s[v]) chk("idle_quiet", int'({in_ready_s[v], fiv_s[v]}), 0);
      end
      chk("stray_done", int'(done_s[1-u]), 0);
      if (busy_s[u] && in_valid_s[u] && !in_ready_s[u]) stalls++;
      if (in_valid_s[u] && in_ready_s[u]) idx++;
      if (done_s[u]) begin
         dones++;
         done_cyc = cyc;
         chk("result_at_done", int'(res_s[u]), exp_res);
      end
   endtask

   task automatic run(input int u, input int n, input bit tg, input int restart_off,
                      output logic [15:0] got);
      real sum;
      int  start_cyc;
      sum = 0.0;
      for (int k = 0; k < n; k++) sum += fp2r(ea[k]) * fp2r(eb[k]);
      exp_res = int'(r2fp(sum));
      tog = tg; idx = 0; n_el = n; issues = 0; dones = 0; stalls = 0;
      step(u, 1'b1, n[7:0]);
      start_cyc = cyc;
      for (int k = 0; k < 600 && dones == 0; k++) step(u, (k == restart_off), 8'd1);
      for (int k = 0; k < 8; k++) step(u, 1'b0, 8'd0);
      chk("done_count", dones, 1);
      chk("issue_count", issues, (n == 0) ? 0 : n + 3);
      chk("result_held", int'(res_s[u]), exp_res);
      if (n == 0) chk("len0_latency", done_cyc - start_cyc, 1);
      got = res_s[u];
      $display("run unit=%0d len=%0d toggle=%0d issues=%0d stalls=%0d result=%h expected=%h",
               u, n, tg, issues, stalls, got, exp_res[15:0]);
   endtask

   task automatic fill_rand(input int n);
      int ka;
      int kb;
      for (int k = 0; k < n; k++) begin
         ka = int'($urandom_range(0, 6)) - 3;
         kb = int'($urandom_range(0, 6)) - 3;
         ea[k] = r2fp(real'(ka));
         eb[k] = r2fp(real'(kb));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got;
      for (int v = 0; v < 2; v++) begin
         start_s[v] = 1'b0; len_s[v] = '0; in_valid_s[v] = 1'b0;
         in_a_s[v] = '0; in_b_s[v] = '0; fov_s[v] = 1'b0; fo_s[v] = '0;
         for (int k = 0; k < 16; k++) begin line_v[v][k] = 1'b0; line_d[v][k] = '0; end
      end
      #2 rst_n = 1'b0;
      #1;
      for (int v = 0; v < 2; v++) begin
         chk("reset_ctrl", int'({busy_s[v], in_ready_s[v], fiv_s[v], done_s[v]}), 0);
         chk("reset_result", int'(res_s[v]), 0);
      end
      step(0, 1'b0, 8'd0);
      step(0, 1'b0, 8'd0);
      rst_n = 1'b1;
      step(0, 1'b0, 8'd0);

      // Four pairs of 1.0*2.0 streamed back-to-back: 8.0.
      for (int k = 0; k < 4; k++) begin ea[k] = 16'h3C00; eb[k] = 16'h4000; end
      run(0, 4, 1'b0, -1, got);
      chk("basic_result", int'(got), 16'h4800);
      chk("basic_issues", issues, 7);

      run(0, 0, 1'b0, -1, got);
      chk("len0_result", int'(got), 16'h0000);

      // Eight 1.0*1.0 pairs with in_valid every other cycle.
      for (int k = 0; k < 8; k++) begin ea[k] = 16'h3C00; eb[k] = 16'h3C00; end
      run(0, 8, 1'b1, -1, got);
      chk("toggle_result", int'(got), 16'h4800);
      chk("toggle_issues", issues, 11);

      // Abort after two issues; their late returns must not leak into the next run.
      for (int k = 0; k < 4; k++) begin ea[k] = 16'h3C00; eb[k] = 16'h4000; end
      exp_res = 16'h4800; tog = 1'b0; idx = 0; n_el = 4; issues = 0;
      step(0, 1'b1, 8'd4);
      for (int k = 0; k < 50 && issues < 2; k++) step(0, 1'b0, 8'd0);
      chk("pre_abort_issues", issues, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ctrl", int'({busy_s[0], in_ready_s[0], fiv_s[0], done_s[0]}), 0);
      chk("abort_result", int'(res_s[0]), 0);
      n_el = 0; idx = 0;
      step(0, 1'b0, 8'd0);
      rst_n = 1'b1;
      ea[0] = 16'h3C00; eb[0] = 16'h3C00;
      run(0, 1, 1'b0, -1, got);
      chk("post_abort_result", int'(got), 16'h3C00);

      // A start pulse mid-operation with a different length must be ignored.
      fill_rand(6);
      run(0, 6, 1'b0, 2, got);

      // Latency-6 FMA with five back-to-back pairs must stall the stream.
      fill_rand(5);
      run(1, 5, 1'b0, -1, got);
      chk("lat6_stall_seen", int'(stalls > 0), 1);

      for (int u = 0; u < 2; u++) begin
         for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            fill_rand(n);
            run(u, n, bit'($urandom_range(0, 1)), -1, got);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
